uc_move_entidades: RTL and testbench

// - Parametrised successor of the asteroid movement control unit. One start pulse walks
//   all N_SLOTS entity slots of an external entity memory (asteroids or shots).
// - For each loaded slot: applies an 8-direction step of STEP units, handles screen edges
//   (wrap or despawn), and writes the result back. Pulses done when the walk finishes.
// - Owns its own slot counter and position arithmetic. Sits between the game-tick timer
//   and the entity memories.

---
 rtl/uc_move_entidades_pkg.sv | 56 +++++
 rtl/uc_move_entidades_passo.sv | 56 +++++
 rtl/uc_move_entidades.sv | 152 +++++++++++++++
 tb/tb_uc_move_entidades.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_move_entidades_pkg.sv
// uc_move_entidades_pkg
//   Shared definitions for the entity movement control unit: FSM state
//   codes, direction opcodes, the debug error code, and the opcode decoder
//   that turns a 3-bit direction into per-axis enable/decrement commands.
package uc_move_entidades_pkg;

  typedef enum logic [2:0] {
    INICIO   = 3'd0,
    ESPERA   = 3'd1,
    LE       = 3'd2,
    CALCULA  = 3'd3,
    ESCREVE  = 3'd4,
    PROXIMO  = 3'd5,
    SINALIZA = 3'd6
  } estado_t;

  localparam logic [4:0] DB_ERRO = 5'b11111;

  // Single-axis codes keep the legacy 2-bit meaning when the MSB is 0.
  localparam logic [2:0] OP_PX   = 3'b000;
  localparam logic [2:0] OP_NX   = 3'b001;
  localparam logic [2:0] OP_PY   = 3'b010;
  localparam logic [2:0] OP_NY   = 3'b011;
  localparam logic [2:0] OP_PXPY = 3'b100;
  localparam logic [2:0] OP_PXNY = 3'b101;
  localparam logic [2:0] OP_NXPY = 3'b110;
  localparam logic [2:0] OP_NXNY = 3'b111;

  typedef struct packed {
    logic en;
    logic dec;
  } eixo_cmd_t;

  typedef struct packed {
    eixo_cmd_t y;
    eixo_cmd_t x;
  } mov_t;

  function automatic mov_t decodifica(input logic [2:0] op);
    mov_t m;
    m = '0;
    case (op)
      OP_PX:   begin m.x.en = 1'b1; end
      OP_NX:   begin m.x.en = 1'b1; m.x.dec = 1'b1; end
      OP_PY:   begin m.y.en = 1'b1; end
      OP_NY:   begin m.y.en = 1'b1; m.y.dec = 1'b1; end
      OP_PXPY: begin m.x.en = 1'b1; m.y.en = 1'b1; end
      OP_PXNY: begin m.x.en = 1'b1; m.y.en = 1'b1; m.y.dec = 1'b1; end
      OP_NXPY: begin m.x.en = 1'b1; m.x.dec = 1'b1; m.y.en = 1'b1; end
      OP_NXNY: begin m.x.en = 1'b1; m.x.dec = 1'b1; m.y.en = 1'b1; m.y.dec = 1'b1; end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/uc_move_entidades_passo.sv
// passo_coordenada
//   One-axis step: moves coordinate c by STEP (up or down) within [0, MAX].
//   Leaving the range either wraps around (WRAP=1) or flags borda and keeps
//   c unchanged (WRAP=0).
//   c       in   COORD_W  current coordinate
//   dir_en  in   1        this axis moves
//   dir_dec in   1        1: decrement, 0: increment
//   c_next  out  COORD_W  new coordinate
//   borda   out  1        entity left the screen (only when WRAP=0)
module passo_coordenada #(
  parameter int COORD_W = 4,
  parameter int MAX     = 15,
  parameter int STEP    = 1,
  parameter int WRAP    = 1
) (
  input  logic [COORD_W-1:0] c,
  input  logic               dir_en,
  input  logic               dir_dec,
  output logic [COORD_W-1:0] c_next,
  output logic               borda
);

  // One extra bit so c+STEP cannot overflow before the range test.
  localparam int W = COORD_W + 1;
  localparam logic [W-1:0] STP  = W'(STEP);
  localparam logic [W-1:0] LIM  = W'(MAX);
  localparam logic [W-1:0] LIM1 = W'(MAX + 1);

  logic [W-1:0] ce, s;

  assign ce = {1'b0, c};
  assign s  = ce + STP;

  always_comb begin
    c_next = c;
    borda  = 1'b0;
    if (dir_en) begin
      if (!dir_dec) begin
        if (s > LIM) begin
          if (WRAP != 0) c_next = COORD_W'(s - LIM1);
          else           borda  = 1'b1;
        end else begin
          c_next = COORD_W'(s);
        end
      end else begin
        if (ce < STP) begin
          if (WRAP != 0) c_next = COORD_W'(ce + LIM1 - STP);
          else           borda  = 1'b1;
        end else begin
          c_next = COORD_W'(ce - STP);
        end
      end
    end
  end

endmodule

// File: rtl/uc_move_entidades.sv
// uc_move_entidades
//   Movement control unit. One movimenta pulse walks every entity slot of
//   an external memory; each loaded slot is read, stepped in one of eight
//   directions, and written back (or despawned at a screen edge when
//   WRAP=0). movimentacao_concluida pulses once at the end of the walk.
//   clock, reset            clock / async active-high reset
//   movimenta               start request, only looked at in ESPERA
//   mem_addr                slot index (memory reads are combinational)
//   mem_rd_{loaded,opcode,x,y}  current slot contents
//   mem_we, mem_wr_{x,y,loaded} one-cycle write-back of the slot
//   ocupado                 walk in progress (LE..SINALIZA)
//   movimentacao_concluida  done pulse
//   db_estado               state code, 31 for an illegal state
module uc_move_entidades
  import uc_move_entidades_pkg::*;
#(
  parameter  int N_SLOTS = 16,
  parameter  int COORD_W = 4,
  parameter  int X_MAX   = 15,
  parameter  int Y_MAX   = 15,
  parameter  int STEP    = 1,
  parameter  int WRAP    = 1,
  localparam int ADDR_W  = $clog2(N_SLOTS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               movimenta,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_rd_loaded,
  input  logic [2:0]         mem_rd_opcode,
  input  logic [COORD_W-1:0] mem_rd_x,
  input  logic [COORD_W-1:0] mem_rd_y,
  output logic               mem_we,
  output logic [COORD_W-1:0] mem_wr_x,
  output logic [COORD_W-1:0] mem_wr_y,
  output logic               mem_wr_loaded,
  output logic               ocupado,
  output logic               movimentacao_concluida,
  output logic [4:0]         db_estado
);

  estado_t estado, prox;

  logic [ADDR_W-1:0] idx;
  logic              ultimo;

  mov_t                    mv;
  logic [1:0]              en, dec, borda;
  logic [1:0][COORD_W-1:0] c_at, c_nx;   // [0] = x, [1] = y

  logic [COORD_W-1:0] wr_x_q, wr_y_q;
  logic               wr_ld_q;

  assign ultimo = (idx == ADDR_W'(N_SLOTS - 1));

  // Per-axis stepping, straight off the combinational memory read.
  assign mv   = decodifica(mem_rd_opcode);
  assign en   = {mv.y.en,  mv.x.en};
  assign dec  = {mv.y.dec, mv.x.dec};
  assign c_at = {mem_rd_y, mem_rd_x};

  for (genvar ax = 0; ax < 2; ax++) begin : g_eixo
    passo_coordenada #(
      .COORD_W (COORD_W),
      .MAX     (ax == 0 ? X_MAX : Y_MAX),
      .STEP    (STEP),
      .WRAP    (WRAP)
    ) u_passo (
      .c       (c_at[ax]),
      .dir_en  (en[ax]),
      .dir_dec (dec[ax]),
      .c_next  (c_nx[ax]),
      .borda   (borda[ax])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIO;
    else       estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      INICIO:   prox = ESPERA;
      ESPERA:   if (movimenta) prox = LE;
      LE:       prox = mem_rd_loaded ? CALCULA : PROXIMO;
      CALCULA:  prox = ESCREVE;
      ESCREVE:  prox = PROXIMO;
      PROXIMO:  prox = ultimo ? SINALIZA : LE;
      SINALIZA: prox = ESPERA;
      default:  prox = INICIO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (estado == ESPERA && movimenta) begin
      idx <= '0;
    end else if (estado == PROXIMO && !ultimo) begin
      idx <= idx + 1'b1;
    end
  end

  // Results are captured in CALCULA so the write-back data is held stable
  // through ESCREVE regardless of what the memory read port does.
  // Hitting an edge on either axis despawns the whole entity in place.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_x_q  <= '0;
      wr_y_q  <= '0;
      wr_ld_q <= 1'b0;
    end else if (estado == CALCULA) begin
      if (|borda) begin
        wr_x_q  <= mem_rd_x;
        wr_y_q  <= mem_rd_y;
        wr_ld_q <= 1'b0;
      end else begin
        wr_x_q  <= c_nx[0];
        wr_y_q  <= c_nx[1];
        wr_ld_q <= 1'b1;
      end
    end
  end

  always_comb begin
    mem_we                 = 1'b0;
    ocupado                = 1'b0;
    movimentacao_concluida = 1'b0;
    db_estado              = {2'b00, estado};
    case (estado)
      INICIO, ESPERA: ;
      LE, CALCULA, PROXIMO: ocupado = 1'b1;
      ESCREVE: begin
        ocupado = 1'b1;
        mem_we  = 1'b1;
      end
      SINALIZA: begin
        ocupado                = 1'b1;
        movimentacao_concluida = 1'b1;
      end
      default: db_estado = DB_ERRO;
    endcase
  end

  assign mem_addr      = idx;
  assign mem_wr_x      = wr_x_q;
  assign mem_wr_y      = wr_y_q;
  assign mem_wr_loaded = wr_ld_q;

endmodule

// File: tb/tb_uc_move_entidades.sv
// tb_uc_move_entidades
//   Three DUTs run in lockstep on identical memory images: (STEP=1,WRAP=1),
//   (STEP=1,WRAP=0) and (STEP=3,WRAP=1), all with N_SLOTS=4. A walk-level
//   model predicts final memory contents, write counts per slot and the
//   cycle of every done pulse.
module tb_uc_move_entidades;
  localparam int N  = 4;
  localparam int ND = 3;

  typedef struct packed {
    logic       ld;
    logic [2:0] op;
    logic [3:0] x;
    logic [3:0] y;
  } slot_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic movimenta = 1'b0;
  logic load_req = 1'b0;

  always #5 clock = ~clock;

  logic [1:0] addr [ND];
  logic       rl   [ND];
  logic [2:0] rop  [ND];
  logic [3:0] rx   [ND];
  logic [3:0] ry   [ND];
  logic       we   [ND];
  logic       wl   [ND];
  logic [3:0] wx   [ND];
  logic [3:0] wy   [ND];
  logic       busy [ND];
  logic       done [ND];
  logic [4:0] db   [ND];

  slot_t mem [ND][N];
  slot_t img [N];
  slot_t mdl [ND][N];
  int    wcnt  [ND][N];
  int    exp_w [ND][N];

  int step_of [ND] = '{1, 1, 3};
  int wrap_of [ND] = '{1, 0, 1};

  int n_chk = 0;
  int n_err = 0;

  uc_move_entidades #(.N_SLOTS(N), .STEP(1), .WRAP(1)) dut_a (
    .clock(clock), .reset(reset), .movimenta(movimenta), .mem_addr(addr[0]),
    .mem_rd_loaded(rl[0]), .mem_rd_opcode(rop[0]), .mem_rd_x(rx[0]), .mem_rd_y(ry[0]),
    .mem_we(we[0]), .mem_wr_x(wx[0]), .mem_wr_y(wy[0]), .mem_wr_loaded(wl[0]),
    .ocupado(busy[0]), .movimentacao_concluida(done[0]), .db_estado(db[0]));

  uc_move_entidades #(.N_SLOTS(N), .STEP(1), .WRAP(0)) dut_b (
    .clock(clock), .reset(reset), .movimenta(movimenta), .mem_addr(addr[1]),
    .mem_rd_loaded(rl[1]), .mem_rd_opcode(rop[1]), .mem_rd_x(rx[1]), .mem_rd_y(ry[1]),
    .mem_we(we[1]), .mem_wr_x(wx[1]), .mem_wr_y(wy[1]), .mem_wr_loaded(wl[1]),
    .ocupado(busy[1]), .movimentacao_concluida(done[1]), .db_estado(db[1]));

  uc_move_entidades #(.N_SLOTS(N), .STEP(3), .WRAP(1)) dut_c (
    .clock(clock), .reset(reset), .movimenta(movimenta), .mem_addr(addr[2]),
    .mem_rd_loaded(rl[2]), .mem_rd_opcode(rop[2]), .mem_rd_x(rx[2]), .mem_rd_y(ry[2]),
    .mem_we(we[2]), .mem_wr_x(wx[2]), .mem_wr_y(wy[2]), .mem_wr_loaded(wl[2]),
    .ocupado(busy[2]), .movimentacao_concluida(done[2]), .db_estado(db[2]));

  // Entity memories: combinational read, write on the clock edge.
  always_comb begin
    for (int k = 0; k < ND; k++) begin
      rl[k]  = mem[k][addr[k]].ld;
      rop[k] = mem[k][addr[k]].op;
      rx[k]  = mem[k][addr[k]].x;
      ry[k]  = mem[k][addr[k]].y;
    end
  end

  always @(posedge clock) begin
    if (load_req) begin
      for (int k = 0; k < ND; k++)
        for (int s = 0; s < N; s++) begin
          mem[k][s]  <= img[s];
          wcnt[k][s] <= 0;
        end
    end else begin
      for (int k = 0; k < ND; k++)
        if (we[k]) begin
          mem[k][addr[k]]  <= {wl[k], mem[k][addr[k]].op, wx[k], wy[k]};
          wcnt[k][addr[k]] <= wcnt[k][addr[k]] + 1;
        end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int dx_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd4, 3'd5: return 1;
      3'd1, 3'd6, 3'd7: return -1;
      default:          return 0;
    endcase
  endfunction

  function automatic int dy_of(input logic [2:0] op);
    case (op)
      3'd2, 3'd4, 3'd6: return 1;
      3'd3, 3'd5, 3'd7: return -1;
      default:          return 0;
    endcase
  endfunction

  // Screen is 0..15 on both axes.
  task automatic ax_step(input int c, input int d, input int st, input int wr,
                         output int nc, output bit e);
    int t;
    t  = c + d * st;
    nc = c;
    e  = 1'b0;
    if (d != 0) begin
      if (t < 0 || t > 15) begin
        if (wr != 0) nc = (t + 16) % 16;
        else         e  = 1'b1;
      end else begin
        nc = t;
      end
    end
  endtask

  task automatic model_walk(input int k, output int nl);
    int nx, ny;
    bit ex, ey;
    nl = 0;
    for (int s = 0; s < N; s++) begin
      if (mdl[k][s].ld) begin
        nl++;
        exp_w[k][s]++;
        ax_step(int'(mdl[k][s].x), dx_of(mdl[k][s].op), step_of[k], wrap_of[k], nx, ex);
        ax_step(int'(mdl[k][s].y), dy_of(mdl[k][s].op), step_of[k], wrap_of[k], ny, ey);
        if (ex || ey) begin
          mdl[k][s].ld = 1'b0;
        end else begin
          mdl[k][s].x = 4'(nx);
          mdl[k][s].y = 4'(ny);
        end
      end
    end
  endtask

  task automatic load_img();
    @(negedge clock);
    load_req = 1'b1;
    @(negedge clock);
    load_req = 1'b0;
    for (int k = 0; k < ND; k++)
      for (int s = 0; s < N; s++) mdl[k][s] = img[s];
  endtask

  // movimenta is high during cycles 0..hold-1 (cycle n ends at edge n+1).
  // A walk sampled at edge e finishes with done during cycle e+lat-1.
  task automatic run(input string nm, input int hold);
    int q_exp [ND][$];
    int q_got [ND][$];
    int last, e, nl, lat;
    last = 0;
    for (int k = 0; k < ND; k++) begin
      for (int s = 0; s < N; s++) exp_w[k][s] = 0;
      e = 1;
      while (1) begin
        model_walk(k, nl);
        lat = 2 * N + 2 * nl + 1;
        q_exp[k].push_back(e + lat - 1);
        if (e + lat - 1 > last) last = e + lat - 1;
        if (e + lat <= hold - 1) e = e + lat + 1;
        else break;
      end
    end
    @(negedge clock);
    movimenta = 1'b1;
    for (int cyc = 1; cyc <= last + 3; cyc++) begin
      @(negedge clock);
      if (cyc >= hold) movimenta = 1'b0;
      if (cyc == 1) begin
        chk($sformatf("%s busy_c1", nm), busy[0], 1);
        chk($sformatf("%s db_c1", nm), db[0], 2);
      end
      for (int k = 0; k < ND; k++)
        if (done[k]) q_got[k].push_back(cyc);
    end
    movimenta = 1'b0;
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("%s d%0d n_done", nm, k), q_got[k].size(), q_exp[k].size());
      for (int i = 0; i < q_exp[k].size() && i < q_got[k].size(); i++)
        chk($sformatf("%s d%0d done_cyc%0d", nm, k, i), q_got[k][i], q_exp[k][i]);
      for (int s = 0; s < N; s++) begin
        chk($sformatf("%s d%0d slot%0d", nm, k, s), mem[k][s], mdl[k][s]);
        chk($sformatf("%s d%0d wcnt%0d", nm, k, s), wcnt[k][s], exp_w[k][s]);
      end
      chk($sformatf("%s d%0d idle", nm, k), db[k], 1);
    end
  endtask

  task automatic rand_img();
    for (int s = 0; s < N; s++) begin
      img[s].ld = 1'($urandom_range(0, 1));
      img[s].op = 3'($urandom_range(0, 7));
      img[s].x  = 4'($urandom_range(0, 15));
      img[s].y  = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    @(negedge clock);
    @(negedge clock);
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("rst d%0d outs", k),
          {we[k], done[k], busy[k], addr[k], db[k], wx[k], wy[k], wl[k]}, 0);
    end
    reset = 1'b0;
    @(negedge clock);
    for (int k = 0; k < ND; k++) chk($sformatf("rst d%0d espera", k), db[k], 1);

    // all unloaded: no writes, done after 9 cycles
    for (int s = 0; s < N; s++) img[s] = {1'b0, 3'($urandom_range(0, 7)), 4'd3, 4'd9};
    load_img();
    run("empty", 1);

    // one diagonal entity in slot 2
    for (int s = 0; s < N; s++) img[s] = '0;
    img[2] = {1'b1, 3'b100, 4'd5, 4'd5};
    load_img();
    run("diag", 1);
    chk("diag literal", mem[0][2], {1'b1, 3'b100, 4'd5 + 4'd1, 4'd6});

    // screen edges
    img[0] = {1'b1, 3'b000, 4'd15, 4'd7};
    img[1] = {1'b1, 3'b011, 4'd9,  4'd0};
    img[2] = {1'b1, 3'b000, 4'd14, 4'd2};
    img[3] = {1'b1, 3'b001, 4'd0,  4'd8};
    load_img();
    run("edges", 1);
    chk("wrap x15+1", mem[0][0].x, 0);
    chk("wrap y0-1", mem[0][1].y, 15);
    chk("wrap x14+3", mem[2][2].x, 1);
    chk("despawn x0-1", mem[1][3], {1'b0, 3'b001, 4'd0, 4'd8});

    // movimenta held high: ignored mid-walk, back-to-back walks from slot 0
    rand_img();
    load_img();
    run("hold", 40);

    // reset while writing slot 1
    for (int s = 0; s < N; s++) img[s] = '0;
    img[1] = {1'b1, 3'b000, 4'd3, 4'd3};
    load_img();
    @(negedge clock);
    movimenta = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      movimenta = 1'b0;
    end
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("abort d%0d we_before", k), we[k], 1);
      chk($sformatf("abort d%0d addr_before", k), addr[k], 1);
    end
    reset = 1'b1;
    #1;
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("abort d%0d we", k), we[k], 0);
      chk($sformatf("abort d%0d db", k), db[k], 0);
      chk($sformatf("abort d%0d addr", k), addr[k], 0);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("abort d%0d espera", k), db[k], 1);
      chk($sformatf("abort d%0d nowrite", k), wcnt[k][1], 0);
      chk($sformatf("abort d%0d slot1", k), mem[k][1], img[1]);
    end
    run("after_abort", 1);

    // random images, some with movimenta held
    for (int r = 0; r < 8; r++) begin
      rand_img();
      load_img();
      run($sformatf("rnd%0d", r), (r % 3 == 0) ? int'($urandom_range(2, 45)) : 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
